// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, position counters and sync/blank strobes out.
interface vga_timing_gen_if #(
   parameter int unsigned HW = 11,
   parameter int unsigned VW = 10,
   parameter int unsigned FW = 8
);
   logic          ce;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          hsync;
   logic          vsync;
   logic          hblnk;
   logic          vblnk;
   logic          line_start;
   logic          frame_start;
   logic [FW-1:0] frame_cnt;

   modport master (
      input  ce,
      output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, frame_cnt
   );

   modport slave (
      output ce,
      input  hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered sync/blank/start strobes,
// frame counter and an optional ce-qualified output delay line.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 1024,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 136,
   parameter int unsigned H_BP     = 160,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 3,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 29,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned DELAY    = 0,
   parameter int unsigned HW       = 11,
   parameter int unsigned VW       = 10,
   parameter int unsigned FW       = 8
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   if (DELAY > 15) begin : g_err_delay
      $error("DELAY must be in 0..15");
   end
   if ((64'(H_TOTAL) - 64'd1) >= (64'd1 << HW)) begin : g_err_hw
      $error("H_TOTAL-1 does not fit in HW bits");
   end
   if ((64'(V_TOTAL) - 64'd1) >= (64'd1 << VW)) begin : g_err_vw
      $error("V_TOTAL-1 does not fit in VW bits");
   end

   typedef struct packed {
      logic [HW-1:0] hcount;
      logic [VW-1:0] vcount;
      logic          hsync;
      logic          vsync;
      logic          hblnk;
      logic          vblnk;
      logic          line_start;
      logic          frame_start;
      logic [FW-1:0] frame_cnt;
   } bundle_t;

   // Bundle describing position (0,0) of a fresh frame.
   localparam bundle_t RST_BUNDLE = '{
      hcount:      '0,
      vcount:      '0,
      hsync:       ~HS_POL,
      vsync:       ~VS_POL,
      hblnk:       1'b0,
      vblnk:       1'b0,
      line_start:  1'b1,
      frame_start: 1'b1,
      frame_cnt:   '0
   };

   bundle_t       r_cnt;
   bundle_t       w_nxt;
   bundle_t       w_out;
   logic          w_h_last;
   logic          w_v_last;
   logic [HW-1:0] w_h_nxt;
   logic [VW-1:0] w_v_nxt;
   logic [FW-1:0] w_f_nxt;

   assign w_h_last = (r_cnt.hcount == H_LAST);
   assign w_v_last = (r_cnt.vcount == V_LAST);

   always_comb begin
      w_h_nxt = r_cnt.hcount + HW'(1);
      w_v_nxt = r_cnt.vcount;
      w_f_nxt = r_cnt.frame_cnt;
      if (w_h_last) begin
         w_h_nxt = '0;
         w_v_nxt = w_v_last ? '0 : r_cnt.vcount + VW'(1);
         if (w_v_last) begin
            w_f_nxt = r_cnt.frame_cnt + FW'(1);
         end
      end
   end

   // Flags decode the next position so they land in the same register as the count.
   always_comb begin
      w_nxt             = RST_BUNDLE;
      w_nxt.hcount      = w_h_nxt;
      w_nxt.vcount      = w_v_nxt;
      w_nxt.frame_cnt   = w_f_nxt;
      w_nxt.hblnk       = (32'(w_h_nxt) >= H_ACTIVE);
      w_nxt.vblnk       = (32'(w_v_nxt) >= V_ACTIVE);
      w_nxt.hsync       = (32'(w_h_nxt) >= HS_BEG && 32'(w_h_nxt) < HS_END) ? HS_POL : ~HS_POL;
      w_nxt.vsync       = (32'(w_v_nxt) >= VS_BEG && 32'(w_v_nxt) < VS_END) ? VS_POL : ~VS_POL;
      w_nxt.line_start  = (w_h_nxt == '0);
      w_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= RST_BUNDLE;
      end else if (vga.ce) begin
         r_cnt <= w_nxt;
      end
   end

   if (DELAY == 0) begin : g_no_dly
      assign w_out = r_cnt;
   end else begin : g_dly
      bundle_t r_pipe [DELAY];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(DELAY); i++) begin
               r_pipe[i] <= RST_BUNDLE;
            end
         end else if (vga.ce) begin
            r_pipe[0] <= r_cnt;
            for (int i = 1; i < int'(DELAY); i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
         end
      end

      assign w_out = r_pipe[DELAY-1];
   end

   assign vga.hcount      = w_out.hcount;
   assign vga.vcount      = w_out.vcount;
   assign vga.hsync       = w_out.hsync;
   assign vga.vsync       = w_out.vsync;
   assign vga.hblnk       = w_out.hblnk;
   assign vga.vblnk       = w_out.vblnk;
   assign vga.line_start  = w_out.line_start;
   assign vga.frame_start = w_out.frame_start;
   assign vga.frame_cnt   = w_out.frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default, DELAY=3 and a small FW=2 raster driven by one ce/rst,
// each compared every clock against a bench-side raster model.
module tb_vga_timing_gen;

   typedef logic [45:0] pk_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.HW(11), .VW(10), .FW(8)) if_def ();
   vga_timing_gen_if #(.HW(11), .VW(10), .FW(8)) if_dly ();
   vga_timing_gen_if #(.HW(5),  .VW(4),  .FW(2)) if_sml ();

   assign if_def.ce = ce;
   assign if_dly.ce = ce;
   assign if_sml.ce = ce;

   vga_timing_gen #(.DELAY(0)) u_def (.clk(clk), .rst(rst), .vga(if_def));
   vga_timing_gen #(.DELAY(3)) u_dly (.clk(clk), .rst(rst), .vga(if_dly));
   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1), .DELAY(0), .HW(5), .VW(4), .FW(2)
   ) u_sml (.clk(clk), .rst(rst), .vga(if_sml));

   function automatic pk_t pack(input logic [15:0] h, input logic [15:0] v, input logic hs,
                                input logic vs, input logic hb, input logic vb, input logic ls,
                                input logic fs, input logic [7:0] f);
      return {h, v, hs, vs, hb, vb, ls, fs, f};
   endfunction

   // Expected bundle straight from the timing definitions for position (h,v), frame f.
   function automatic pk_t exp_b(input int h, input int v, input int f, input int ha,
                                 input int hs0, input int hs1, input int va, input int vs0,
                                 input int vs1, input logic hp, input logic vp);
      return pack(16'(h), 16'(v), (h >= hs0 && h < hs1) ? hp : ~hp,
                  (v >= vs0 && v < vs1) ? vp : ~vp, h >= ha, v >= va, h == 0,
                  h == 0 && v == 0, 8'(f));
   endfunction

   pk_t obs_def, obs_dly, obs_sml;
   assign obs_def = pack(16'(if_def.hcount), 16'(if_def.vcount), if_def.hsync, if_def.vsync,
                         if_def.hblnk, if_def.vblnk, if_def.line_start, if_def.frame_start,
                         8'(if_def.frame_cnt));
   assign obs_dly = pack(16'(if_dly.hcount), 16'(if_dly.vcount), if_dly.hsync, if_dly.vsync,
                         if_dly.hblnk, if_dly.vblnk, if_dly.line_start, if_dly.frame_start,
                         8'(if_dly.frame_cnt));
   assign obs_sml = pack(16'(if_sml.hcount), 16'(if_sml.vcount), if_sml.hsync, if_sml.vsync,
                         if_sml.hblnk, if_sml.vblnk, if_sml.line_start, if_sml.frame_start,
                         8'(if_sml.frame_cnt));

   int  n_chk = 0;
   int  n_fail = 0;
   int  mh, mv, mf, sh, sv, sf;
   pk_t q_def[$], q_dly[$], q_sml[$];
   pk_t last_def, last_dly, last_sml;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic pk_t e_def();
      return exp_b(mh, mv, mf, 1024, 1048, 1184, 768, 771, 777, 1'b0, 1'b0);
   endfunction

   function automatic pk_t e_sml();
      return exp_b(sh, sv, sf, 16, 18, 22, 8, 9, 11, 1'b1, 1'b1);
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; mf = 0; sh = 0; sv = 0; sf = 0;
      q_def.delete(); q_dly.delete(); q_sml.delete();
      // The DELAY=3 stages all hold the reset bundle until three ce have passed.
      for (int i = 0; i < 3; i++) q_dly.push_back(e_def());
      last_def = e_def(); last_dly = e_def(); last_sml = e_sml();
   endtask

   task automatic model_advance();
      mh++;
      if (mh == 1344) begin
         mh = 0; mv++;
         if (mv == 806) begin mv = 0; mf = (mf + 1) % 256; end
      end
      sh++;
      if (sh == 25) begin
         sh = 0; sv++;
         if (sv == 13) begin sv = 0; sf = (sf + 1) % 4; end
      end
   endtask

   task automatic step(input logic ce_v);
      ce = ce_v;
      @(posedge clk);
      #1;
      if (ce_v && !rst) begin
         model_advance();
         q_def.push_back(e_def());
         q_dly.push_back(e_def());
         q_sml.push_back(e_sml());
         last_def = q_def.pop_front();
         last_dly = q_dly.pop_front();
         last_sml = q_sml.pop_front();
      end
      check_eq("def", 64'(obs_def), 64'(last_def));
      check_eq("dly", 64'(obs_dly), 64'(last_dly));
      check_eq("sml", 64'(obs_sml), 64'(last_sml));
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_eq({tag, "_def"}, 64'(obs_def), 64'(last_def));
      check_eq({tag, "_dly"}, 64'(obs_dly), 64'(last_dly));
      check_eq({tag, "_sml"}, 64'(obs_sml), 64'(last_sml));
      check_eq({tag, "_const"}, 64'(obs_def),
               64'(pack(16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0)));
      step(1'b1);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs_lo, hs_first, hb_n;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      apply_reset("por");

      hs_lo = 0; hs_first = -1; hb_n = 0;
      for (int i = 1; i <= 1343; i++) begin
         step(1'b1);
         if (!if_def.hsync) begin
            if (hs_first < 0) hs_first = int'(if_def.hcount);
            hs_lo++;
         end
         if (if_def.hblnk) hb_n++;
         if (i == 199) check_eq("sml_vblnk_lo", 64'(if_sml.vblnk), 64'(0));
         if (i == 200) check_eq("sml_vblnk_hi", 64'(if_sml.vblnk), 64'(1));
         if (i % 325 == 0) begin
            check_eq("sml_fcnt", 64'(if_sml.frame_cnt), 64'((i / 325) % 4));
            check_eq("sml_fstart", 64'(if_sml.frame_start), 64'(1));
         end
      end
      check_eq("h_last", 64'(if_def.hcount), 64'(1343));
      check_eq("h_last_v", 64'(if_def.vcount), 64'(0));
      check_eq("hsync_low_cnt", 64'(hs_lo), 64'(136));
      check_eq("hsync_first", 64'(hs_first), 64'(1048));
      check_eq("hblnk_cnt", 64'(hb_n), 64'(320));
      step(1'b1);
      check_eq("h_wrap", 64'(if_def.hcount), 64'(0));
      check_eq("v_inc", 64'(if_def.vcount), 64'(1));

      apply_reset("tog");
      for (int i = 0; i < 2688; i++) begin
         step(i % 2 == 0);
         if (i == 2685) check_eq("tog_h_last", 64'(if_def.hcount), 64'(1343));
      end
      check_eq("tog_h_wrap", 64'(if_def.hcount), 64'(0));
      check_eq("tog_v_inc", 64'(if_def.vcount), 64'(1));

      apply_reset("pre_mid");
      repeat (1844) step(1'b1);
      check_eq("mid_pos_h", 64'(if_def.hcount), 64'(500));
      check_eq("mid_pos_v", 64'(if_def.vcount), 64'(1));
      check_eq("mid_sml_hs", 64'(if_sml.hsync), 64'(1));
      apply_reset("mid");
      step(1'b1);
      check_eq("post_rst_h", 64'(if_def.hcount), 64'(1));
      check_eq("post_rst_v", 64'(if_def.vcount), 64'(0));
      check_eq("post_rst_sml_h", 64'(if_sml.hcount), 64'(1));
      check_eq("post_rst_sml_hs", 64'(if_sml.hsync), 64'(0));
      repeat (60) step(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
